// File: rtl/higher_memory_arbiter.sv
// Round-robin arbiter merging several cache-side valid/fulfilled request channels
// onto one higher-memory channel, one outstanding transaction at a time.
package higher_memory_arbiter_pkg;
   typedef enum logic {
      MEM_LOAD  = 1'b0,
      MEM_STORE = 1'b1
   } memory_operation_e;
endpackage

module higher_memory_arbiter
   import higher_memory_arbiter_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int NUM_REQUESTERS = 2,
   parameter int ID_W           = $clog2(NUM_REQUESTERS)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [XLEN-1:0]           up_req_address     [NUM_REQUESTERS],
   input  memory_operation_e         up_req_operation   [NUM_REQUESTERS],
   input  logic [XLEN-1:0]           up_req_store_word  [NUM_REQUESTERS],
   input  logic [NUM_REQUESTERS-1:0] up_req_valid,
   output logic [XLEN-1:0]           up_req_loaded_word [NUM_REQUESTERS],
   output logic [NUM_REQUESTERS-1:0] up_req_fulfilled,
   output logic [XLEN-1:0]           mem_req_address,
   output memory_operation_e         mem_req_operation,
   output logic [XLEN-1:0]           mem_req_store_word,
   output logic                      mem_req_valid,
   input  logic [XLEN-1:0]           mem_req_loaded_word,
   input  logic                      mem_req_fulfilled,
   output logic [ID_W-1:0]           grant_id,
   output logic                      busy
);

   typedef enum logic {
      IDLE,
      BUSY
   } state_e;

   state_e          state;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] pick_id;
   logic            pick_found;

   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= NUM_REQUESTERS) sum = sum - NUM_REQUESTERS;
      return ID_W'(sum);
   endfunction

   // Scan from the highest offset down so the requester nearest the pointer wins.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
         if (up_req_valid[wrap_add(rr_ptr, k)]) begin
            pick_found = 1'b1;
            pick_id    = wrap_add(rr_ptr, k);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state              <= IDLE;
         rr_ptr             <= '0;
         grant_id           <= '0;
         mem_req_valid      <= 1'b0;
         busy               <= 1'b0;
         mem_req_address    <= '0;
         mem_req_operation  <= MEM_LOAD;
         mem_req_store_word <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  mem_req_address    <= up_req_address[pick_id];
                  mem_req_operation  <= up_req_operation[pick_id];
                  mem_req_store_word <= up_req_store_word[pick_id];
                  grant_id           <= pick_id;
                  mem_req_valid      <= 1'b1;
                  busy               <= 1'b1;
                  state              <= BUSY;
               end
            end
            BUSY: begin
               // Returning to IDLE for one cycle lets the requester drop valid first.
               if (mem_req_fulfilled) begin
                  mem_req_valid <= 1'b0;
                  busy          <= 1'b0;
                  rr_ptr        <= wrap_add(grant_id, 1);
                  state         <= IDLE;
               end
            end
            default: begin
               mem_req_valid <= 1'b0;
               busy          <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         up_req_fulfilled[i]   = 1'b0;
         up_req_loaded_word[i] = '0;
         if ((state == BUSY) && mem_req_fulfilled && (grant_id == ID_W'(i))) begin
            up_req_fulfilled[i]   = 1'b1;
            up_req_loaded_word[i] = mem_req_loaded_word;
         end
      end
   end

endmodule

// File: tb/tb_higher_memory_arbiter.sv
// Bench for higher_memory_arbiter: requester/memory models drive traffic, a
// negedge monitor checks grants and responses against a round-robin reference.
module tb_higher_memory_arbiter;
   import higher_memory_arbiter_pkg::*;

   localparam int N    = 4;
   localparam int XLEN = 32;
   localparam int IDW  = $clog2(N);
   localparam int D    = 1024;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   logic [XLEN-1:0]   up_req_address     [N];
   memory_operation_e up_req_operation   [N];
   logic [XLEN-1:0]   up_req_store_word  [N];
   logic [N-1:0]      up_req_valid;
   logic [XLEN-1:0]   up_req_loaded_word [N];
   logic [N-1:0]      up_req_fulfilled;
   logic [XLEN-1:0]   mem_req_address;
   memory_operation_e mem_req_operation;
   logic [XLEN-1:0]   mem_req_store_word;
   logic              mem_req_valid;
   logic [XLEN-1:0]   mem_req_loaded_word;
   logic              mem_req_fulfilled;
   logic [IDW-1:0]    grant_id;
   logic              busy;

   always #5 clk = ~clk;

   higher_memory_arbiter #(
      .XLEN(XLEN),
      .NUM_REQUESTERS(N)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .up_req_address(up_req_address),
      .up_req_operation(up_req_operation),
      .up_req_store_word(up_req_store_word),
      .up_req_valid(up_req_valid),
      .up_req_loaded_word(up_req_loaded_word),
      .up_req_fulfilled(up_req_fulfilled),
      .mem_req_address(mem_req_address),
      .mem_req_operation(mem_req_operation),
      .mem_req_store_word(mem_req_store_word),
      .mem_req_valid(mem_req_valid),
      .mem_req_loaded_word(mem_req_loaded_word),
      .mem_req_fulfilled(mem_req_fulfilled),
      .grant_id(grant_id),
      .busy(busy)
   );

   // Stimulus-side state: per-requester transaction queues and expected responses.
   logic [XLEN-1:0] rq_addr  [N][D];
   logic            rq_op    [N][D];
   logic [XLEN-1:0] rq_data  [N][D];
   logic [XLEN-1:0] exp_word [N][D];
   int              rq_wr    [N];
   int              rq_rd    [N];
   int              consumed [N];
   logic [N-1:0]    drop;
   logic [N-1:0]    scr;
   logic            mem_stall;
   logic            spur;
   logic            gen_en;
   int              mem_cnt;
   int              tmo;
   int              gseq [64];
   int              gs_wr;
   logic            end_req;

   // Monitor-side state.
   int              n_cmp = 0;
   int              n_bad = 0;
   int              rd [N] = '{default: 0};
   int              m_rr = 0;
   int              m_gnt = 0;
   logic            m_pend = 1'b0;
   logic            m_act = 1'b0;
   logic [XLEN-1:0] m_addr = '0;
   logic [XLEN-1:0] m_data = '0;
   logic            m_op = 1'b0;
   logic [N-1:0]    exp_ful = '0;
   int              gs_rd = 0;
   logic            end_done = 1'b0;

   function automatic logic [XLEN-1:0] mem_fn(input logic [XLEN-1:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
   endfunction

   function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
      for (int j = 0; j < N; j++) begin
         if (v[(ptr + j) % N]) return (ptr + j) % N;
      end
      return 0;
   endfunction

   function automatic logic pending();
      for (int i = 0; i < N; i++) begin
         if (rq_rd[i] < rq_wr[i]) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk or negedge reset_n);
         if (!reset_n) begin
            #1;
            chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_grant_id", 32'(grant_id), 32'd0);
            chk("rst_mem_req_address", mem_req_address, 32'd0);
            chk("rst_mem_req_store_word", mem_req_store_word, 32'd0);
            chk("rst_mem_req_operation", 32'(mem_req_operation), 32'd0);
            chk("rst_up_req_fulfilled", 32'(up_req_fulfilled), 32'd0);
            m_rr   = 0;
            m_gnt  = 0;
            m_pend = 1'b0;
            m_act  = 1'b0;
            for (int i = 0; i < N; i++) rd[i] = rq_wr[i];
         end else begin
            if (m_pend) begin
               chk("grant_valid", 32'(mem_req_valid), 32'd1);
               chk("grant_busy", 32'(busy), 32'd1);
               chk("grant_id", 32'(grant_id), 32'(m_gnt));
               chk("grant_address", mem_req_address, m_addr);
               chk("grant_operation", 32'(mem_req_operation), 32'(m_op));
               chk("grant_store_word", mem_req_store_word, m_data);
               if (gs_rd < gs_wr) begin
                  chk("grant_sequence", 32'(grant_id), 32'(gseq[gs_rd]));
                  gs_rd++;
               end
               m_pend = 1'b0;
               m_act  = 1'b1;
            end else if (m_act) begin
               chk("busy_valid", 32'(mem_req_valid), 32'd1);
               chk("busy_busy", 32'(busy), 32'd1);
               chk("busy_grant_id", 32'(grant_id), 32'(m_gnt));
               chk("busy_address_held", mem_req_address, m_addr);
               chk("busy_operation_held", 32'(mem_req_operation), 32'(m_op));
               chk("busy_store_word_held", mem_req_store_word, m_data);
            end else begin
               chk("idle_valid", 32'(mem_req_valid), 32'd0);
               chk("idle_busy", 32'(busy), 32'd0);
               chk("idle_grant_id_held", 32'(grant_id), 32'(m_gnt));
            end

            exp_ful = (m_act && mem_req_fulfilled) ? (N'(1) << m_gnt) : '0;
            chk("up_req_fulfilled", 32'(up_req_fulfilled), 32'(exp_ful));
            for (int i = 0; i < N; i++) begin
               if (exp_ful[i]) begin
                  chk("response_expected", 32'(rd[i] < rq_wr[i]), 32'd1);
                  chk("loaded_word", up_req_loaded_word[i], exp_word[i][rd[i] % D]);
                  rd[i]++;
               end else begin
                  chk("ungranted_loaded_word", up_req_loaded_word[i], 32'd0);
               end
            end

            if (m_act && mem_req_fulfilled) begin
               m_act = 1'b0;
               m_rr  = (m_gnt + 1) % N;
            end else if (!m_act && (up_req_valid != '0)) begin
               m_gnt  = rr_pick(up_req_valid, m_rr);
               m_addr = rq_addr[m_gnt][rq_rd[m_gnt] % D];
               m_op   = rq_op[m_gnt][rq_rd[m_gnt] % D];
               m_data = rq_data[m_gnt][rq_rd[m_gnt] % D];
               m_pend = 1'b1;
            end

            if (end_req && !end_done) begin
               for (int i = 0; i < N; i++) chk("responses_drained", 32'(rd[i]), 32'(rq_wr[i]));
               chk("grant_sequence_count", 32'(gs_rd), 32'(gs_wr));
               chk("drain_timeouts", 32'(tmo), 32'd0);
               end_done = 1'b1;
            end
         end
      end
   end

   task automatic issue(input int i, input logic [XLEN-1:0] a, input logic op, input logic [XLEN-1:0] d);
      rq_addr[i][rq_wr[i] % D]  = a;
      rq_op[i][rq_wr[i] % D]    = op;
      rq_data[i][rq_wr[i] % D]  = d;
      exp_word[i][rq_wr[i] % D] = mem_fn(a);
      rq_wr[i]++;
   endtask

   task automatic gpush(input int g);
      gseq[gs_wr] = g;
      gs_wr++;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         while (consumed[i] < rd[i]) begin
            consumed[i]++;
            rq_rd[i]++;
            drop[i] = 1'b0;
            scr[i]  = 1'b0;
         end
      end
      if (gen_en) begin
         for (int i = 0; i < N; i++) begin
            if ((rq_wr[i] - rq_rd[i] < 3) && ($urandom_range(3) == 0))
               issue(i, $urandom, 1'($urandom_range(1)), $urandom);
            if (mem_req_valid && (int'(grant_id) == i)) begin
               if ($urandom_range(7) == 0) drop[i] = 1'b1;
               if ($urandom_range(7) == 0) scr[i] = 1'b1;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         int h = rq_rd[i] % D;
         up_req_valid[i]      = (rq_rd[i] < rq_wr[i]) && !drop[i];
         up_req_address[i]    = scr[i] ? ~rq_addr[i][h] : rq_addr[i][h];
         up_req_operation[i]  = memory_operation_e'(scr[i] ? ~rq_op[i][h] : rq_op[i][h]);
         up_req_store_word[i] = scr[i] ? 32'hFFFF_FFFF : rq_data[i][h];
      end
      mem_req_fulfilled   = 1'b0;
      mem_req_loaded_word = $urandom;
      if (mem_req_valid) begin
         if (!mem_stall && (mem_cnt == 0)) begin
            mem_req_fulfilled   = 1'b1;
            mem_req_loaded_word = mem_fn(mem_req_address);
            mem_cnt             = gen_en ? int'($urandom_range(3)) : 0;
         end else if (mem_cnt > 0) begin
            mem_cnt--;
         end
      end else if (spur || (gen_en && ($urandom_range(7) == 0))) begin
         mem_req_fulfilled = 1'b1;
      end
   endtask

   task automatic drain(input int bound);
      int n = 0;
      while ((pending() || mem_req_valid) && (n < bound)) begin
         cycle();
         n++;
      end
      if (n >= bound) begin
         tmo++;
         $display("FAIL drain_timeout: still busy after %0d cycles, required idle", bound);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      for (int i = 0; i < N; i++) begin
         rq_rd[i]    = rq_wr[i];
         consumed[i] = rq_wr[i];
      end
      drop              = '0;
      scr               = '0;
      up_req_valid      = '0;
      mem_req_fulfilled = 1'b0;
      mem_stall         = 1'b0;
      mem_cnt           = 0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         rq_wr[i]              = 0;
         rq_rd[i]              = 0;
         consumed[i]           = 0;
         up_req_address[i]     = '0;
         up_req_operation[i]   = MEM_LOAD;
         up_req_store_word[i]  = '0;
      end
      up_req_valid        = '0;
      drop                = '0;
      scr                 = '0;
      mem_req_fulfilled   = 1'b0;
      mem_req_loaded_word = '0;
      mem_stall           = 1'b0;
      spur                = 1'b0;
      gen_en              = 1'b0;
      mem_cnt             = 0;
      tmo                 = 0;
      gs_wr               = 0;
      end_req             = 1'b0;
      reset_n             = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Lone requester 1 load.
      issue(1, 32'h0000_1000, 1'b0, 32'h0);
      gpush(1);
      drain(50);

      // Contention from a fresh reset: both requesters alternate.
      do_reset();
      issue(0, 32'h0000_0100, 1'b0, 32'h0);
      issue(1, 32'h0000_0200, 1'b1, 32'hCAFE_0001);
      issue(0, 32'h0000_0104, 1'b1, 32'hCAFE_0002);
      issue(1, 32'h0000_0204, 1'b0, 32'h0);
      gpush(0); gpush(1); gpush(0); gpush(1);
      drain(60);

      // Store passthrough; requester fields scrambled and valid dropped while granted.
      issue(0, 32'h0000_0040, 1'b1, 32'h1234_5678);
      gpush(0);
      mem_stall = 1'b1;
      repeat (3) cycle();
      scr[0]  = 1'b1;
      drop[0] = 1'b1;
      repeat (3) cycle();
      mem_stall = 1'b0;
      drain(30);

      // Fulfilled pulse while idle must be ignored.
      spur = 1'b1;
      cycle();
      spur = 1'b0;
      repeat (2) cycle();

      // Reset during an outstanding transaction returns the pointer to 0.
      issue(2, 32'h0000_0300, 1'b0, 32'h0);
      gpush(2);
      mem_stall = 1'b1;
      repeat (4) cycle();
      do_reset();
      issue(0, 32'h0000_0400, 1'b0, 32'h0);
      issue(1, 32'h0000_0500, 1'b1, 32'h5555_AAAA);
      gpush(0); gpush(1);
      drain(40);

      // Four-way rotation, then a lone requester behind the pointer.
      do_reset();
      issue(0, 32'h0000_1100, 1'b0, 32'h0);
      issue(1, 32'h0000_1200, 1'b0, 32'h0);
      issue(2, 32'h0000_1300, 1'b1, 32'h0BAD_F00D);
      issue(3, 32'h0000_1400, 1'b0, 32'h0);
      issue(0, 32'h0000_1104, 1'b0, 32'h0);
      gpush(0); gpush(1); gpush(2); gpush(3); gpush(0);
      drain(80);
      issue(2, 32'h0000_2000, 1'b0, 32'h0);
      gpush(2);
      drain(30);
      issue(2, 32'h0000_2004, 1'b1, 32'h7777_8888);
      gpush(2);
      drain(30);

      // Randomized traffic.
      gen_en = 1'b1;
      repeat (3000) cycle();
      gen_en = 1'b0;
      drain(500);
      repeat (2) cycle();

      end_req = 1'b1;
      for (int k = 0; (k < 10) && !end_done; k++) @(negedge clk);
      #2;
      if (!end_done) begin
         $display("FAIL final_checks: monitor did not finish, got 0, required 1");
         $fatal(1, "monitor stalled");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/higher_memory_arbiter.md
Name: higher_memory_arbiter

Overview:
- Round-robin arbiter that merges NUM_REQUESTERS cache-side miss/writeback request channels onto one higher-memory channel.
- Each side uses the team's valid/fulfilled memory protocol: the requester holds valid until it sees a one-cycle fulfilled pulse.
- Sits between the cache levels (I$/D$ or multiple cache banks) and the shared higher memory.
- Grants one transaction at a time, registers the request fields on grant, and routes the response back only to the granted requester.

Parameters:
XLEN, 32, address/data word width
NUM_REQUESTERS, 2, number of upstream request channels (>=2)
ID_W, $clog2(NUM_REQUESTERS), derived; width of grant index

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
up_req_address  in  [NUM_REQUESTERS][XLEN]  per-requester address
up_req_operation  in  [NUM_REQUESTERS] memory_operation_e  per-requester operation
up_req_store_word  in  [NUM_REQUESTERS][XLEN]  per-requester store data
up_req_valid  in  NUM_REQUESTERS  per-requester request valid
up_req_loaded_word  out  [NUM_REQUESTERS][XLEN]  returned load data
up_req_fulfilled  out  NUM_REQUESTERS  per-requester completion pulse
mem_req_address  out  XLEN  registered address to higher memory
mem_req_operation  out  memory_operation_e  registered operation
mem_req_store_word  out  XLEN  registered store data
mem_req_valid  out  1  request valid to higher memory
mem_req_loaded_word  in  XLEN  load data from higher memory
mem_req_fulfilled  in  1  completion pulse from higher memory
grant_id  out  ID_W  index of current/last granted requester
busy  out  1  high while a transaction is outstanding

Behaviour:
- Reset (async, reset_n=0): state=IDLE; mem_req_valid=0; busy=0; grant_id=0; mem_req_address/store_word=0; mem_req_operation=enum value 0; rr pointer=0 (requester 0 highest priority); up_req_fulfilled=0.
- FSM states: IDLE, BUSY.
- IDLE: if any up_req_valid, pick the first valid index searching from rr pointer upward, wrapping modulo NUM_REQUESTERS. At clock edge: latch that requester's address/operation/store_word into the mem_req_* registers, grant_id<=index, state<=BUSY. If no requester is valid, stay in IDLE.
- BUSY: mem_req_valid=1, busy=1; mem_req_* fields held stable.
  - On a cycle with mem_req_fulfilled=1: up_req_fulfilled[grant_id]=1 and up_req_loaded_word[grant_id]=mem_req_loaded_word, combinationally in the same cycle.
  - At that clock edge: state<=IDLE, rr pointer<=(grant_id+1) mod NUM_REQUESTERS.
- up_req_fulfilled bits for non-granted requesters are always 0. up_req_loaded_word for non-granted requesters is 0.
- Latency:
  - Request valid in cycle T while IDLE -> mem_req_valid=1 in T+1.
  - Fulfilled in cycle F -> mem_req_valid=0 in F+1 (a mandatory one-cycle IDLE gap).
  - Next grant is decided in F+1 and issued in F+2. The gap prevents re-issuing a request whose valid drops after fulfilled.
- Fairness: a continuously valid requester waits at most NUM_REQUESTERS-1 transactions.
- Requester deasserting up_req_valid while granted: the transaction still completes to memory, and the fulfilled pulse is still delivered to that index.
- Requester field changes while granted: ignored, because the fields are registered.
- mem_req_fulfilled while IDLE: ignored; no up_req_fulfilled asserted; no state change.
- Reset asserted mid-BUSY: mem_req_valid drops immediately (asynchronously); the outstanding transaction is abandoned; rr pointer returns to 0.
- grant_id holds its last value while IDLE.

Test Plan:
- Single requester: up_req_valid[1]=1, addr=0x0000_1000, op=load, at T -> mem_req_valid=1 and mem_req_address=0x0000_1000 at T+1, grant_id=1. Memory fulfills at T+4 with word 0xDEAD_BEEF -> up_req_fulfilled=2'b10 and up_req_loaded_word[1]=0xDEAD_BEEF in T+4; mem_req_valid=0 at T+5.
- Contention after reset: both requesters valid at T -> requester 0 granted first. After its fulfill, requester 1 is granted, with mem_req_valid re-rising exactly 2 cycles after the fulfill cycle. Both held valid for 4 transactions -> grant sequence 0,1,0,1.
- Store passthrough: requester 0 store, addr 0x40, data 0x1234_5678 -> mem_req_store_word=0x1234_5678 and the store operation appear. Changing up_req_store_word[0] to 0xFFFF_FFFF mid-BUSY -> mem_req_store_word unchanged.
- Spurious fulfill: mem_req_fulfilled=1 while IDLE -> up_req_fulfilled=0, busy stays 0, no grant.
- Reset mid-transaction: reset_n=0 during BUSY -> mem_req_valid=0 immediately. After release with both requesters valid -> requester 0 granted (pointer reset).
- NUM_REQUESTERS=4, all valid, each fulfilled after 1 cycle -> grants 0,1,2,3,0. Only requester 2 valid while pointer=3 -> wrap finds 2, granted.
